// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: groups the I-cache, D-cache and cacheline-adapter signals of cache_arbiter.
// Ports: i_* = I-cache line reads; d_* = D-cache line reads/writebacks; ca_* = adapter side.
// Modports: slave = arbiter view; master = environment view (both caches plus the adapter).
interface cache_arbiter_if #(
  parameter int s_line = 256
);
  // I-cache side
  logic [31:0]       i_addr;
  logic              i_read;
  logic [s_line-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic [31:0]       d_addr;
  logic              d_read;
  logic              d_write;
  logic [s_line-1:0] d_wdata;
  logic [s_line-1:0] d_rdata;
  logic              d_resp;
  // cacheline adapter side
  logic [31:0]       ca_addr;
  logic              ca_read;
  logic              ca_write;
  logic [s_line-1:0] ca_wdata;
  logic [s_line-1:0] ca_rdata;
  logic              ca_resp;

  modport slave (
    input  i_addr, i_read,
    output i_rdata, i_resp,
    input  d_addr, d_read, d_write, d_wdata,
    output d_rdata, d_resp,
    output ca_addr, ca_read, ca_write, ca_wdata,
    input  ca_rdata, ca_resp
  );

  modport master (
    output i_addr, i_read,
    input  i_rdata, i_resp,
    output d_addr, d_read, d_write, d_wdata,
    input  d_rdata, d_resp,
    input  ca_addr, ca_read, ca_write, ca_wdata,
    output ca_rdata, ca_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cacheline adapter between the I-cache and the D-cache.
// Latency: adapter request 1 cycle after a request is seen in idle; x_resp is ca_resp passed through.
// Backpressure: the losing requester holds its request; it is arbitrated at the next idle cycle.
// Ports: clk, rst (synchronous, active-high), bus (cache_arbiter_if.slave: i_*, d_*, ca_*).
// Config: CACHE_ARBITER_RR_EN defined -> round-robin on contention; undefined -> D-cache always wins.
module cache_arbiter #(
  parameter int s_line = 256
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    s_idle    = 2'd0,
    s_serve_i = 2'd1,
    s_serve_d = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Transaction captured at grant time; the adapter only ever sees these,
  // so requesters may change or drop their inputs while being served.
  logic [31:0]       r_addr;
  logic [s_line-1:0] r_wdata;
  logic              r_op_write;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_ca_read;
  logic              w_ca_write;
  logic              w_i_resp;
  logic              w_d_resp;

  assign w_req_i = bus.i_read;
  assign w_req_d = bus.d_read | bus.d_write;

`ifdef CACHE_ARBITER_RR_EN
  // Last-grant register, updated only on contention: 1 means the D-cache won
  // the most recent contention, so the I-cache leads the next one.  Clearing
  // it on reset lets the D-cache lead the first contention.
  logic r_last_d;
  logic w_both;

  assign w_both    = w_req_i & w_req_d;
  assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == s_idle && w_both) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = w_req_d;
`endif

  assign w_grant_i = w_req_i & ~w_grant_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= s_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and adapter/response controls
  always_comb begin
    w_state_nxt = r_state;
    w_ca_read   = 1'b0;
    w_ca_write  = 1'b0;
    w_i_resp    = 1'b0;
    w_d_resp    = 1'b0;
    case (r_state)
      s_idle: begin
        // ca_resp is deliberately ignored here
        if (w_grant_d) begin
          w_state_nxt = s_serve_d;
        end else if (w_grant_i) begin
          w_state_nxt = s_serve_i;
        end
      end
      s_serve_i: begin
        w_ca_read  = ~r_op_write;
        w_ca_write = r_op_write;
        if (bus.ca_resp) begin
          w_i_resp    = 1'b1;
          w_state_nxt = s_idle;
        end
      end
      s_serve_d: begin
        w_ca_read  = ~r_op_write;
        w_ca_write = r_op_write;
        if (bus.ca_resp) begin
          w_d_resp    = 1'b1;
          w_state_nxt = s_idle;
        end
      end
      default: begin
        w_state_nxt = s_idle;
      end
    endcase
  end

  // Capture the winner in idle.  A simultaneous d_read/d_write is a writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op_write <= 1'b0;
    end else if (r_state == s_idle) begin
      if (w_grant_d) begin
        r_addr     <= bus.d_addr;
        r_wdata    <= bus.d_wdata;
        r_op_write <= bus.d_write;
      end else if (w_grant_i) begin
        r_addr     <= bus.i_addr;
        r_wdata    <= '0;
        r_op_write <= 1'b0;
      end
    end
  end

  // Reset abandons an in-flight transaction: no request, no completion pulse
  // even if the adapter answers in the reset cycle.
  assign bus.ca_read  = w_ca_read & ~rst;
  assign bus.ca_write = w_ca_write & ~rst;
  assign bus.i_resp   = w_i_resp & ~rst;
  assign bus.d_resp   = w_d_resp & ~rst;
  assign bus.ca_addr  = r_addr;
  assign bus.ca_wdata = r_wdata;

  // Line data goes to both caches unconditionally; x_resp qualifies it.
  assign bus.i_rdata  = bus.ca_rdata;
  assign bus.d_rdata  = bus.ca_rdata;

  a_ca_onehot: assert property (@(posedge clk) disable iff (rst) !(bus.ca_read && bus.ca_write));
  a_resp_excl: assert property (@(posedge clk) disable iff (rst) !(bus.i_resp && bus.d_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  localparam int SL = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_arbiter_if #(.s_line(SL)) bus ();
  cache_arbiter #(.s_line(SL)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   addr;
    logic          wr;
    logic [SL-1:0] wdata;
    int            stamp;
  } ca_exp_t;

  typedef struct {
    logic          who_d;
    logic [SL-1:0] rdata;
  } rsp_exp_t;

  ca_exp_t  exp_ca[$];
  rsp_exp_t exp_rsp[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus controls
  logic          rst_req = 1'b1;
  logic          rand_en = 1'b0, mut_en = 1'b0, spur_en = 1'b0, force_spur = 1'b0;
  int            ad_lat = 1;
  logic          cmd_i = 1'b0, cmd_d = 1'b0, cmd_d_rd = 1'b0, cmd_d_wr = 1'b0, cmd_d_move = 1'b0;
  logic [31:0]   cmd_i_addr = '0, cmd_d_addr = '0, cmd_d_addr2 = '0;
  logic [SL-1:0] cmd_d_wdata = '0;

  // driver state
  logic busy_i = 1'b0, busy_d = 1'b0, done_i = 1'b0, done_d = 1'b0, ad_busy = 1'b0;
  int   gap_i = 0, gap_d = 0, ad_cnt = 0;

  // reference model: one adapter transaction at a time; D wins contention
  // (round-robin build: the side that lost the previous contention wins)
  logic m_busy = 1'b0, m_who_d = 1'b0, m_last_i = 1'b1;

  logic    mon_en = 1'b0;
  logic    mon_prev = 1'b0;
  ca_exp_t mon_cur;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b, need %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, need %h", name, cyc, act, exp);
    end
  endtask

  task automatic chkl(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, need %h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [SL-1:0] rand_line();
    logic [SL-1:0] v;
    for (int k = 0; k < SL / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle of stimulus: requesters, adapter, then the reference model.
  task automatic step();
    logic     pend_i, pend_d, win_d;
    int       k;
    ca_exp_t  e;
    rsp_exp_t r;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    bus.ca_rdata = rand_line();
    if (rst_req) begin
      bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.ca_resp = 1'b0;
      busy_i = 1'b0; busy_d = 1'b0; done_i = 1'b0; done_d = 1'b0; ad_busy = 1'b0;
      m_busy = 1'b0; m_last_i = 1'b1;
      exp_ca.delete();
      exp_rsp.delete();
      return;
    end
    // requesters
    if (done_i) begin done_i = 1'b0; busy_i = 1'b0; bus.i_read = 1'b0; gap_i = $urandom_range(0, 4); end
    if (done_d) begin done_d = 1'b0; busy_d = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; gap_d = $urandom_range(0, 4); end
    if (cmd_i) begin cmd_i = 1'b0; busy_i = 1'b1; bus.i_read = 1'b1; bus.i_addr = cmd_i_addr; end
    if (cmd_d) begin
      cmd_d = 1'b0; busy_d = 1'b1;
      bus.d_read = cmd_d_rd; bus.d_write = cmd_d_wr; bus.d_addr = cmd_d_addr; bus.d_wdata = cmd_d_wdata;
    end
    if (cmd_d_move) begin cmd_d_move = 1'b0; bus.d_addr = cmd_d_addr2; end
    if (rand_en && !busy_i) begin
      if (gap_i == 0) begin busy_i = 1'b1; bus.i_read = 1'b1; bus.i_addr = $urandom & 32'hFFFF_FFE0; end
      else gap_i--;
    end else if (rand_en && m_busy && !m_who_d && bus.i_read && $urandom_range(0, 15) == 0) begin
      bus.i_read = 1'b0;
    end
    if (rand_en && !busy_d) begin
      if (gap_d == 0) begin
        k = $urandom_range(0, 2);
        busy_d = 1'b1;
        bus.d_read  = (k != 1);
        bus.d_write = (k != 0);
        bus.d_addr  = $urandom & 32'hFFFF_FFE0;
        bus.d_wdata = rand_line();
      end else gap_d--;
    end else if (rand_en && m_busy && m_who_d && $urandom_range(0, 15) == 0) begin
      bus.d_read = 1'b0; bus.d_write = 1'b0;
    end
    if (mut_en && busy_d && m_busy && m_who_d && $urandom_range(0, 3) == 0) begin
      bus.d_addr  = $urandom & 32'hFFFF_FFE0;
      bus.d_wdata = rand_line();
    end
    // adapter
    bus.ca_resp = 1'b0;
    if (bus.ca_read || bus.ca_write) begin
      if (!ad_busy) begin ad_busy = 1'b1; ad_cnt = (ad_lat >= 0) ? ad_lat : $urandom_range(0, 5); end
      if (ad_cnt == 0) begin bus.ca_resp = 1'b1; ad_busy = 1'b0; end
      else ad_cnt--;
    end else if (force_spur || (spur_en && $urandom_range(0, 9) == 0)) begin
      bus.ca_resp = 1'b1;
    end
    force_spur = 1'b0;
    // reference model
    if (m_busy) begin
      if (bus.ca_resp) begin
        r.who_d = m_who_d;
        r.rdata = bus.ca_rdata;
        exp_rsp.push_back(r);
        m_busy = 1'b0;
        if (m_who_d) done_d = 1'b1; else done_i = 1'b1;
      end
    end else begin
      pend_i = bus.i_read;
      pend_d = bus.d_read || bus.d_write;
      if (pend_i || pend_d) begin
`ifdef CACHE_ARBITER_RR_EN
        if (pend_i && pend_d) begin win_d = m_last_i; m_last_i = !win_d; end
        else win_d = pend_d;
`else
        win_d = pend_d;
`endif
        e.addr  = win_d ? bus.d_addr : bus.i_addr;
        e.wr    = win_d && bus.d_write;
        e.wdata = bus.d_wdata;
        e.stamp = cyc;
        exp_ca.push_back(e);
        m_busy  = 1'b1;
        m_who_d = win_d;
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    step();
    while ((m_busy || busy_i || busy_d) && n < bound) begin
      step();
      n++;
    end
    if (m_busy || busy_i || busy_d) fail_now("drain_timeout");
    step();
  endtask

  // monitor / scoreboard
  initial begin
    logic     active;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        active = bus.ca_read || bus.ca_write;
        chk1("ca_rd_wr_excl", bus.ca_read && bus.ca_write, 1'b0);
        chkl("i_rdata_pass", bus.i_rdata, bus.ca_rdata);
        chkl("d_rdata_pass", bus.d_rdata, bus.ca_rdata);
        if (active && !mon_prev) begin
          if (exp_ca.size() > 0 && exp_ca[0].stamp < cyc) mon_cur = exp_ca.pop_front();
          else fail_now("unexpected_adapter_start");
        end
        if (exp_ca.size() > 0 && exp_ca[0].stamp < cyc) begin
          fail_now("late_adapter_start");
          void'(exp_ca.pop_front());
        end
        if (active) begin
          chk32("ca_addr", bus.ca_addr, mon_cur.addr);
          chk1("ca_write", bus.ca_write, mon_cur.wr);
          chk1("ca_read", bus.ca_read, !mon_cur.wr);
          if (mon_cur.wr) chkl("ca_wdata", bus.ca_wdata, mon_cur.wdata);
        end
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          chk1("i_resp", bus.i_resp, !r.who_d);
          chk1("d_resp", bus.d_resp, r.who_d);
          chkl("resp_rdata", r.who_d ? bus.d_rdata : bus.i_rdata, r.rdata);
        end else begin
          chk1("i_resp_quiet", bus.i_resp, 1'b0);
          chk1("d_resp_quiet", bus.d_resp, 1'b0);
        end
        mon_prev = active;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SL-1:0] pat_b;
    pat_b = {8{32'hB0B1_B2B3}};
    bus.i_addr = '0; bus.i_read = 1'b0;
    bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.ca_rdata = '0; bus.ca_resp = 1'b0;

    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    step();
    #3;
    chk1("rst_ca_read", bus.ca_read, 1'b0);
    chk1("rst_ca_write", bus.ca_write, 1'b0);
    chk1("rst_i_resp", bus.i_resp, 1'b0);
    chk1("rst_d_resp", bus.d_resp, 1'b0);
    chk32("rst_ca_addr", bus.ca_addr, 32'h0);
    chkl("rst_ca_wdata", bus.ca_wdata, '0);
    mon_en = 1'b1;

    // I-cache read, adapter answers after 4 cycles
    ad_lat = 4; cmd_i = 1'b1; cmd_i_addr = 32'h0000_0100;
    wait_idle(50);

    // D-cache writeback
    ad_lat = 2; cmd_d = 1'b1; cmd_d_rd = 1'b0; cmd_d_wr = 1'b1;
    cmd_d_addr = 32'h8000_0020; cmd_d_wdata = pat_b;
    wait_idle(50);

    // simultaneous I and D reads, twice
    ad_lat = 1;
    for (int rep = 0; rep < 2; rep++) begin
      cmd_i = 1'b1; cmd_i_addr = 32'h0000_1000 + 32'(rep) * 32'h40;
      cmd_d = 1'b1; cmd_d_rd = 1'b1; cmd_d_wr = 1'b0; cmd_d_addr = 32'h0000_2000 + 32'(rep) * 32'h40;
      cmd_d_wdata = rand_line();
      wait_idle(50);
    end

    // d_read and d_write together: the writeback is taken
    cmd_d = 1'b1; cmd_d_rd = 1'b1; cmd_d_wr = 1'b1; cmd_d_addr = 32'h0000_3000; cmd_d_wdata = rand_line();
    wait_idle(50);

    // D address moves while being served
    ad_lat = 5; cmd_d = 1'b1; cmd_d_rd = 1'b1; cmd_d_wr = 1'b0; cmd_d_addr = 32'h0000_0040;
    step();
    step();
    cmd_d_move = 1'b1; cmd_d_addr2 = 32'h0000_0060;
    wait_idle(50);

    // reset in the middle of a D transaction
    ad_lat = 8; cmd_d = 1'b1; cmd_d_rd = 1'b1; cmd_d_wr = 1'b0; cmd_d_addr = 32'h0000_0040;
    repeat (3) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    #3;
    chk1("rst_mid_ca_read", bus.ca_read, 1'b0);
    chk1("rst_mid_ca_write", bus.ca_write, 1'b0);
    chk1("rst_mid_d_resp", bus.d_resp, 1'b0);
    step();
    #3;
    chk1("rst_mid_stays_idle", bus.ca_read, 1'b0);

    // contention right after reset (round-robin pointer is back at its reset value)
    ad_lat = 1;
    cmd_i = 1'b1; cmd_i_addr = 32'h0000_5000;
    cmd_d = 1'b1; cmd_d_rd = 1'b1; cmd_d_wr = 1'b0; cmd_d_addr = 32'h0000_6000;
    wait_idle(50);

    // adapter pulse while idle with nothing requested
    force_spur = 1'b1;
    step();
    #3;
    chk1("spur_i_resp", bus.i_resp, 1'b0);
    chk1("spur_d_resp", bus.d_resp, 1'b0);
    step();
    #3;
    chk1("spur_stays_idle", bus.ca_read || bus.ca_write, 1'b0);

    // randomized traffic
    ad_lat = -1; rand_en = 1'b1; mut_en = 1'b1; spur_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0; mut_en = 1'b0; spur_en = 1'b0;
    wait_idle(300);
    step();
    chk32("exp_ca_left", 32'(exp_ca.size()), 32'h0);
    chk32("exp_rsp_left", 32'(exp_rsp.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
